receptor_palavra: RTL and testbench
===================================

# receptor_palavra

Parametrised word-receiver control and assembly block, the successor to the fixed two-byte receiver control unit. It sits behind the serial byte receiver and collects `N_BYTES` parity-checked bytes, least-significant first, into one word. It enforces an inter-byte timeout and reports completion (`pronto`) or a coded error (`erro` + `codigo_erro`). The output word changes only on a fully successful reception; partial or failed words never reach `dado`.

## Interface
- `N_BYTES`, 2: bytes per word, ≥ 1.
- `TIMEOUT_CICLOS`, 50000: maximum idle cycles between bytes of one word; 0 disables the timeout.
- `clock`  in  1  single system clock, rising edge.
- `reset`  in  1  synchronous, active-low reset (0 on a rising edge of `clock` resets the block).
- `fim_receber`  in  1  one-cycle pulse from the byte receiver: a byte is available.
- `dado_byte`  in  8  received byte; valid only in the `fim_receber` cycle.
- `parity_ok`  in  1  parity result; valid only in the `fim_receber` cycle.
- `dado`  out  8*N_BYTES  last complete word; byte k is received byte k, at bits [8k+7:8k].
- `pronto`  out  1  one-cycle pulse: `dado` has just been updated.
- `erro`  out  1  one-cycle pulse: the current word was discarded.
- `codigo_erro`  out  2  cause of the last error: 00 none, 01 parity, 10 timeout. Holds its value until the next `pronto` or `erro`.
- `db_estado`  out  3  current FSM state, for debug.
- `db_indice`  out  clog2(N_BYTES+1)  index of the next byte expected.

## Operation
- States (3-bit encoding): RECEBE=0, CARREGA=1, FIM=2, ERRO=3. Unused codes go to RECEBE.
- RECEBE:
  - `fim_receber`=1 and `parity_ok`=1: capture `dado_byte` into `byte_reg`, go to CARREGA.
  - `fim_receber`=1 and `parity_ok`=0: go to ERRO with code 01.
  - Timeout expired (see below) and no `fim_receber`: go to ERRO with code 10.
  - Otherwise stay.
- CARREGA:
  - Write `byte_reg` into buffer slot `indice`.
  - If `indice`=N_BYTES-1: load `dado` with the complete buffer (including this byte), clear `indice`, go to FIM.
  - Else: `indice`+1, go to RECEBE.
- FIM: `pronto`=1, `codigo_erro`←00, go to RECEBE.
- ERRO: `erro`=1, `codigo_erro` set to the cause, `indice`←0, partial buffer discarded, go to RECEBE.
- `fim_receber` seen in CARREGA, FIM or ERRO is ignored; that byte is lost.
- Timeout counter:
  - Cleared in every state except RECEBE, and on every `fim_receber`.
  - Increments each cycle spent in RECEBE with `indice`>0.
  - Expires when it equals `TIMEOUT_CICLOS`.
  - No timeout while `indice`=0: idle waiting for a word is unbounded.
- Counter width: clog2(TIMEOUT_CICLOS+1). Saturates; never wraps.

## Timing
- Reset values: state RECEBE, `indice` 0, `dado` all zeros, `pronto` 0, `erro` 0, `codigo_erro` 00, counter 0, `byte_reg` 0.
- Reset mid-word discards the partial word. `dado` returns to zero.
- For `fim_receber` at cycle t:
  - Good parity: CARREGA at t+1.
  - Good parity on the last byte: FIM at t+2, and `dado` is valid in the same cycle as `pronto`.
  - Bad parity: ERRO at t+1, with `erro`=1 and `codigo_erro` valid together.
- Timeout boundary:
  - `fim_receber` in the `TIMEOUT_CICLOS`-th idle cycle is accepted (`fim_receber` wins).
  - Otherwise ERRO follows in the next cycle.
- Minimum spacing between accepted bytes: 2 cycles. N_BYTES=1: `pronto` 2 cycles after each good byte.

## Structure
- Package `receptor_pkg`: state encodings RECEBE/CARREGA/FIM/ERRO, error codes ERRO_NENHUM/ERRO_PARIDADE/ERRO_TIMEOUT.
- Sub-module `contador_timeout`:
  - Parameter `TIMEOUT_CICLOS`.
  - Inputs `clock`, `reset`, `zera`, `conta`.
  - Output `expirou`, tied to 0 when `TIMEOUT_CICLOS`=0.
- Top level holds the FSM, `byte_reg`, the buffer and the `dado` register.

## Test plan
- N_BYTES=2: good bytes 0x34 then 0x12 → `dado`=0x1234, single `pronto` 2 cycles after the second `fim_receber`, `codigo_erro`=00.
- After that word, byte 0x55 good then 0x66 with `parity_ok`=0 → `erro` pulse, `codigo_erro`=01, `dado` stays 0x1234, `db_indice` back to 0.
- TIMEOUT_CICLOS=20: one good byte, then silence → `erro` in the 21st cycle after re-entering RECEBE, `codigo_erro`=10. Repeat with `fim_receber` in the 20th cycle → accepted, no error.
- Reset driven low after the first byte of a word, then released → all outputs at reset values. A fresh 2-byte word 0xBB, 0xAA → `dado`=0xAABB.
- N_BYTES=4: bytes 0x78, 0x56, 0x34, 0x12 with 5-cycle gaps → `dado`=0x12345678, exactly one `pronto`.
- `fim_receber` asserted during CARREGA/FIM → byte ignored, `db_indice` unaffected.

Source files
------------

// File: rtl/receptor_pkg.sv
// Shared encodings for the word receiver: FSM state codes and error cause codes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package receptor_pkg;

  // FSM state encoding; the 3-bit code is exported on db_estado
  typedef enum logic [2:0] {
    RECEBE  = 3'd0,
    CARREGA = 3'd1,
    FIM     = 3'd2,
    ERRO    = 3'd3
  } estado_t;

  // Cause reported on codigo_erro
  localparam logic [1:0] ERRO_NENHUM   = 2'b00;
  localparam logic [1:0] ERRO_PARIDADE = 2'b01;
  localparam logic [1:0] ERRO_TIMEOUT  = 2'b10;

endpackage

// File: rtl/contador_timeout.sv
// Inter-byte idle counter: counts while enabled, saturates at TIMEOUT_CICLOS and flags expiry.
// Latency: expirou is combinational from the counter register (no extra cycle).
// Backpressure: none; zera has priority over conta, TIMEOUT_CICLOS=0 disables expiry.
module contador_timeout #(
  parameter int TIMEOUT_CICLOS = 50000
) (
  input  logic clock,
  input  logic reset,
  input  logic zera,
  input  logic conta,
  output logic expirou
);

  // A zero timeout would give a zero-width counter; keep one bit so the logic stays legal.
  localparam int CW = (TIMEOUT_CICLOS > 0) ? $clog2(TIMEOUT_CICLOS + 1) : 1;
  localparam logic [CW-1:0] LIMITE = CW'(TIMEOUT_CICLOS);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise increment until the limit and hold there.
  always_comb begin
    cnt_d = cnt_q;
    if (zera) begin
      cnt_d = '0;
    end else if (conta && (cnt_q != LIMITE)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expirou = (TIMEOUT_CICLOS == 0) ? 1'b0 : (cnt_q == LIMITE);

endmodule

// File: rtl/receptor_palavra.sv
// Assembles N_BYTES parity-checked bytes (LSB first) into a word, with inter-byte timeout.
// Latency: pronto and the new dado appear 2 cycles after the last good byte; erro 1 cycle after a bad byte.
// Backpressure: none; bytes arriving while the FSM is in CARREGA/FIM/ERRO are dropped.
module receptor_palavra
  import receptor_pkg::*;
#(
  parameter int N_BYTES        = 2,
  parameter int TIMEOUT_CICLOS = 50000
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         fim_receber,
  input  logic [7:0]                   dado_byte,
  input  logic                         parity_ok,
  output logic [8*N_BYTES-1:0]         dado,
  output logic                         pronto,
  output logic                         erro,
  output logic [1:0]                   codigo_erro,
  output logic [2:0]                   db_estado,
  output logic [$clog2(N_BYTES+1)-1:0] db_indice
);

  localparam int IW = $clog2(N_BYTES + 1);
  localparam logic [IW-1:0] ULTIMO = IW'(N_BYTES - 1);

  estado_t                   estado_q, estado_d;
  logic [IW-1:0]             indice_q, indice_d;
  logic [7:0]                byte_q, byte_d;
  logic [N_BYTES-1:0][7:0]   buffer_q, buffer_d;
  logic [8*N_BYTES-1:0]      dado_q, dado_d;
  logic [1:0]                codigo_q, codigo_d;
  logic                      zera, conta, expirou;

  // Idle time only matters between bytes of a word; any other state or a new byte restarts it.
  assign zera  = (estado_q != RECEBE) || fim_receber;
  assign conta = (estado_q == RECEBE) && (indice_q != '0);

  contador_timeout #(
    .TIMEOUT_CICLOS(TIMEOUT_CICLOS)
  ) u_timeout (
    .clock   (clock),
    .reset   (reset),
    .zera    (zera),
    .conta   (conta),
    .expirou (expirou)
  );

  // FSM next state, datapath next values and the pulse outputs.
  always_comb begin
    estado_d = estado_q;
    indice_d = indice_q;
    byte_d   = byte_q;
    buffer_d = buffer_q;
    dado_d   = dado_q;
    codigo_d = codigo_q;
    pronto   = 1'b0;
    erro     = 1'b0;

    case (estado_q)
      RECEBE: begin
        // A byte in the expiry cycle still wins over the timeout.
        if (fim_receber) begin
          if (parity_ok) begin
            byte_d   = dado_byte;
            estado_d = CARREGA;
          end else begin
            codigo_d = ERRO_PARIDADE;
            estado_d = ERRO;
          end
        end else if (expirou) begin
          codigo_d = ERRO_TIMEOUT;
          estado_d = ERRO;
        end
      end

      CARREGA: begin
        for (int k = 0; k < N_BYTES; k++) begin
          if (indice_q == IW'(k)) begin
            buffer_d[k] = byte_q;
          end
        end
        if (indice_q == ULTIMO) begin
          // dado is loaded from the updated buffer so the last byte lands in the same word.
          dado_d   = buffer_d;
          indice_d = '0;
          codigo_d = ERRO_NENHUM;
          estado_d = FIM;
        end else begin
          indice_d = indice_q + IW'(1);
          estado_d = RECEBE;
        end
      end

      FIM: begin
        pronto   = 1'b1;
        estado_d = RECEBE;
      end

      ERRO: begin
        erro     = 1'b1;
        indice_d = '0;
        buffer_d = '0;
        estado_d = RECEBE;
      end

      default: begin
        estado_d = RECEBE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      estado_q <= RECEBE;
      indice_q <= '0;
      byte_q   <= '0;
      buffer_q <= '0;
      dado_q   <= '0;
      codigo_q <= ERRO_NENHUM;
    end else begin
      estado_q <= estado_d;
      indice_q <= indice_d;
      byte_q   <= byte_d;
      buffer_q <= buffer_d;
      dado_q   <= dado_d;
      codigo_q <= codigo_d;
    end
  end

  assign dado        = dado_q;
  assign codigo_erro = codigo_q;
  assign db_estado   = estado_q;
  assign db_indice   = indice_q;

endmodule

// File: tb/tb_receptor_palavra.sv
// Bench for receptor_palavra: two instances (2-byte word with 20-cycle timeout, 4-byte word with no timeout).
// Both share the byte stream; an event-level reference model predicts every output each cycle.
// Directed scenarios first, then randomised bytes, parity errors, long silences and resets.
module tb_receptor_palavra;

  logic        clock = 1'b0;
  logic        reset;
  logic        fim_receber;
  logic [7:0]  dado_byte;
  logic        parity_ok;

  logic [15:0] dado_a;
  logic        pronto_a, erro_a;
  logic [1:0]  cod_a;
  logic [2:0]  est_a;
  logic [1:0]  idx_a;

  logic [31:0] dado_b;
  logic        pronto_b, erro_b;
  logic [1:0]  cod_b;
  logic [2:0]  est_b;
  logic [2:0]  idx_b;

  receptor_palavra #(.N_BYTES(2), .TIMEOUT_CICLOS(20)) dut_a (
    .clock(clock), .reset(reset), .fim_receber(fim_receber), .dado_byte(dado_byte),
    .parity_ok(parity_ok), .dado(dado_a), .pronto(pronto_a), .erro(erro_a),
    .codigo_erro(cod_a), .db_estado(est_a), .db_indice(idx_a)
  );

  receptor_palavra #(.N_BYTES(4), .TIMEOUT_CICLOS(0)) dut_b (
    .clock(clock), .reset(reset), .fim_receber(fim_receber), .dado_byte(dado_byte),
    .parity_ok(parity_ok), .dado(dado_b), .pronto(pronto_b), .erro(erro_b),
    .codigo_erro(cod_b), .db_estado(est_b), .db_indice(idx_b)
  );

  always #5 clock = ~clock;

  // Reference model, per instance: words as byte counts and event times, not FSM states.
  int          nb [2] = '{2, 4};
  int          tmo[2] = '{20, 0};
  int          busy_ate[2];
  int          prazo[2];
  int          cnt[2];
  int          pronto_em[2];
  int          erro_em[2];
  int          carrega_em[2];
  logic [31:0] acc[2];
  logic [31:0] pend_word[2];
  logic [31:0] exp_dado[2];
  logic [1:0]  pend_code[2];
  logic [1:0]  exp_code[2];

  int c;
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v)
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h (cycle %0d)", tag, obs, exp_v, c);
    end
  endtask

  task automatic model_reset(input int m);
    busy_ate[m]   = -1;
    prazo[m]      = -1;
    cnt[m]        = 0;
    pronto_em[m]  = -1;
    erro_em[m]    = -1;
    carrega_em[m] = -1;
    acc[m]        = '0;
    pend_word[m]  = '0;
    exp_dado[m]   = '0;
    pend_code[m]  = 2'b00;
    exp_code[m]   = 2'b00;
  endtask

  task automatic check_model(input int m);
    string       nm;
    logic [31:0] od, oi;
    logic        op, oe;
    logic [1:0]  oc;
    logic [2:0]  os;
    nm = (m == 0) ? "A" : "B";
    if (m == 0) begin
      od = {16'h0, dado_a}; oi = {30'h0, idx_a}; op = pronto_a; oe = erro_a; oc = cod_a; os = est_a;
    end else begin
      od = dado_b; oi = {29'h0, idx_b}; op = pronto_b; oe = erro_b; oc = cod_b; os = est_b;
    end
    if (c == pronto_em[m]) begin
      exp_dado[m] = pend_word[m];
      exp_code[m] = 2'b00;
    end
    if (c == erro_em[m]) exp_code[m] = pend_code[m];

    chk({nm, "_pronto"}, 32'(op), 32'(c == pronto_em[m]));
    chk({nm, "_erro"},   32'(oe), 32'(c == erro_em[m]));
    chk({nm, "_dado"},   od,      exp_dado[m]);
    chk({nm, "_codigo"}, 32'(oc), 32'(exp_code[m]));
    if (c == carrega_em[m])      chk({nm, "_estado_carrega"}, 32'(os), 32'd1);
    else if (c == pronto_em[m])  chk({nm, "_estado_fim"},     32'(os), 32'd2);
    else if (c == erro_em[m])    chk({nm, "_estado_erro"},    32'(os), 32'd3);
    else if (c > busy_ate[m]) begin
      chk({nm, "_estado_recebe"}, 32'(os), 32'd0);
      chk({nm, "_indice"},        oi,      32'(cnt[m]));
    end
  endtask

  task automatic update_model(input int m, input logic f, input logic [7:0] b, input logic p, input logic rn);
    if (!rn) begin
      model_reset(m);
    end else if (c <= busy_ate[m]) begin
      // byte (if any) arrives while the block is busy: lost
    end else if (f && p) begin
      carrega_em[m] = c + 1;
      acc[m] = acc[m] | ({24'h0, b} << (8 * cnt[m]));
      cnt[m]++;
      if (cnt[m] == nb[m]) begin
        pronto_em[m] = c + 2;
        pend_word[m] = acc[m];
        acc[m]       = '0;
        cnt[m]       = 0;
        busy_ate[m]  = c + 2;
        prazo[m]     = -1;
      end else begin
        busy_ate[m] = c + 1;
        prazo[m]    = (tmo[m] > 0) ? c + 2 + tmo[m] : -1;
      end
    end else if (f) begin
      erro_em[m]   = c + 1;
      pend_code[m] = 2'b01;
      acc[m]       = '0;
      cnt[m]       = 0;
      busy_ate[m]  = c + 1;
      prazo[m]     = -1;
    end else if (prazo[m] >= 0 && c == prazo[m]) begin
      erro_em[m]   = c + 1;
      pend_code[m] = 2'b10;
      acc[m]       = '0;
      cnt[m]       = 0;
      busy_ate[m]  = c + 1;
      prazo[m]     = -1;
    end
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle, advance the model.
  task automatic step(input logic f, input logic [7:0] b, input logic p, input logic rn);
    fim_receber = f;
    dado_byte   = b;
    parity_ok   = p;
    reset       = rn;
    @(negedge clock);
    for (int m = 0; m < 2; m++) check_model(m);
    for (int m = 0; m < 2; m++) update_model(m, f, b, p, rn);
    @(posedge clock);
    #1;
    c++;
    fim_receber = 1'b0;
    parity_ok   = 1'b0;
    reset       = 1'b1;
  endtask

  task automatic send(input logic [7:0] b, input logic p);
    step(1'b1, b, p, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  initial begin
    reset       = 1'b0;
    fim_receber = 1'b0;
    dado_byte   = 8'h00;
    parity_ok   = 1'b0;
    c           = 0;
    for (int m = 0; m < 2; m++) model_reset(m);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    chk("reset_dado_a",   {16'h0, dado_a}, 32'h0);
    chk("reset_codigo_b", {30'h0, cod_b},  32'h0);

    // Two good bytes form 0x1234 in the 2-byte instance.
    send(8'h34, 1'b1); idle(4);
    send(8'h12, 1'b1); idle(4);
    chk("word_1234", {16'h0, dado_a}, 32'h1234);

    // Good byte then bad parity: word discarded, 0x1234 kept.
    send(8'h55, 1'b1); idle(4);
    send(8'h66, 1'b0); idle(4);
    chk("parity_keeps_1234", {16'h0, dado_a}, 32'h1234);
    chk("parity_code",       {30'h0, cod_a},  32'h1);

    // Silence after one byte times out; then a byte exactly at the limit is accepted.
    send(8'hA1, 1'b1); idle(30);
    chk("timeout_code", {30'h0, cod_a}, 32'h2);
    send(8'hC3, 1'b1); idle(21);
    send(8'hD4, 1'b1); idle(4);
    chk("limit_accepted", {16'h0, dado_a}, 32'hD4C3);

    // Reset mid-word, then a fresh word.
    send(8'h01, 1'b1); idle(2);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("reset_mid_dado_a", {16'h0, dado_a}, 32'h0);
    chk("reset_mid_dado_b", dado_b,          32'h0);
    idle(2);
    send(8'hBB, 1'b1); idle(3);
    send(8'hAA, 1'b1); idle(4);
    chk("word_aabb", {16'h0, dado_a}, 32'hAABB);

    // Four-byte word with 5-cycle spacing.
    step(1'b0, 8'h00, 1'b0, 1'b0);
    send(8'h78, 1'b1); idle(4);
    send(8'h56, 1'b1); idle(4);
    send(8'h34, 1'b1); idle(4);
    send(8'h12, 1'b1); idle(6);
    chk("word_12345678", dado_b, 32'h12345678);

    // Bytes during CARREGA and FIM are dropped.
    send(8'h11, 1'b1);
    send(8'h22, 1'b1);
    send(8'h33, 1'b1);
    idle(1);
    send(8'h44, 1'b1);
    idle(4);
    chk("drop_busy", {16'h0, dado_a}, 32'h3311);

    // Random traffic: bursts, parity errors, long silences, rare resets.
    for (int i = 0; i < 1500; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 1)       step(1'b0, 8'h00, 1'b0, 1'b0);
      else if (r < 4)  idle($urandom_range(15, 28));
      else if (r < 40) send(8'($urandom_range(0, 255)), ($urandom_range(0, 7) != 0));
      else             idle(1);
    end
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
